imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN SHALL default to 32; legal values are 32 and 64; immediate output width.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 INSTR_IN  input  32  SHALL carry the raw instruction word.
REQ-005 in_valid  input  1  SHALL qualify INSTR_IN.
REQ-006 in_ready  output  1  SHALL indicate the block accepts INSTR_IN this cycle; it is driven directly from a register.
REQ-007 flush  input  1  SHALL discard all held entries synchronously.
REQ-008 IMM_OUT  output  XLEN  SHALL carry the extended immediate.
REQ-009 IMM_TYPE  output  3  SHALL carry the format code: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
REQ-010 out_valid  output  1  SHALL qualify IMM_OUT and IMM_TYPE.
REQ-011 out_ready  input  1  SHALL indicate the consumer accepts the output this cycle.

Function
REQ-012 Decode SHALL use INSTR_IN[6:2]: 01101/00101 U; 11011 J; 11001/00000/00001/00100/00110 I; 01000/01001 S; 11000 B; any other value gives type 0 with IMM_OUT zero.
REQ-013 I/S/B/J immediates SHALL be sign-extended from INSTR_IN[31] to XLEN; B and J SHALL have bit 0 = 0; shift-immediate fields SHALL NOT be masked.
REQ-014 U immediate SHALL be {INSTR_IN[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
REQ-015 Transfer SHALL occur on in_valid && in_ready; results SHALL appear on IMM_OUT/out_valid one cycle after acceptance when the output stage is free (latency 1).
REQ-016 Storage SHALL be an output register plus one skid register (2 entries total); order SHALL be preserved.
REQ-017 States: EMPTY (no entries), ONE (output only), TWO (output + skid); in_ready = 1 in EMPTY and ONE, 0 in TWO.
REQ-018 EMPTY: accept -> ONE.
REQ-019 ONE: accept without out_ready -> TWO; accept with out_ready -> ONE, output replaced; no accept with out_ready -> EMPTY.
REQ-020 TWO: out_ready -> ONE, skid moves to output the same edge; no out_ready -> hold TWO.
REQ-021 Output SHALL be held stable while out_valid && !out_ready.
REQ-022 flush SHALL take priority over all transfers: next state EMPTY, in_ready = 1, any same-cycle input dropped.
REQ-023 Full throughput: back-to-back inputs with out_ready held high SHALL produce one output per cycle.

Reset
REQ-024 On rst_n low, asynchronously: state EMPTY, out_valid = 0, in_ready = 1, IMM_OUT = 0, IMM_TYPE = 0, skid contents = 0.
REQ-025 Reset asserted mid-transfer SHALL discard all entries; no output SHALL be produced for inputs accepted before reset.
REQ-026 The first acceptance SHALL be possible on the first rising CLK edge after rst_n deasserts.

Configuration
REQ-027 Macro IMM_GEN_CSR_ZIMM_EN defined: opcode 11100 with INSTR_IN[14] = 1 SHALL give type 6, IMM_OUT = zero-extended INSTR_IN[19:15].
REQ-028 Macro IMM_GEN_CSR_ZIMM_EN undefined: opcode 11100 SHALL give type 0, IMM_OUT zero; no CSR logic present.

Verification
REQ-029 XLEN=32, 0xFFF00093 accepted, out_ready=1 -> next cycle IMM_OUT 0xFFFFFFFF, type 1, out_valid 1.
REQ-030 XLEN=64, 0x80000037 -> IMM_OUT 0xFFFFFFFF80000000, type 4; 0x0040006F -> IMM_OUT 0x4, type 5.
REQ-031 Backpressure: out_ready=0, three valid inputs on consecutive cycles -> first two held, in_ready 0 from cycle 3, third not accepted; out_ready=1 -> outputs drain in order, in_ready returns 1.
REQ-032 flush in state TWO with in_valid=1 -> next cycle out_valid 0, in_ready 1, no further outputs.
REQ-033 0x0002D073 -> with IMM_GEN_CSR_ZIMM_EN: IMM_OUT 0x5, type 6; without: IMM_OUT 0, type 0.
REQ-034 rst_n pulsed low while state TWO -> immediately out_valid 0, in_ready 1, IMM_OUT 0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator behind a 2-entry (output + skid) valid/ready pipeline stage.
// Optional CSR zimm decoding is enabled by defining IMM_GEN_CSR_ZIMM_EN.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic [31:0]     INSTR_IN,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    output logic [XLEN-1:0] IMM_OUT,
    output logic [2:0]      IMM_TYPE,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
`ifdef IMM_GEN_CSR_ZIMM_EN
    localparam logic [2:0] T_Z    = 3'd6;
`endif

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
    logic [2:0]      out_type_q, out_type_d, skid_type_q, skid_type_d;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type;
    logic            accept;
    logic            unused_instr_bits;

    assign unused_instr_bits = ^INSTR_IN[1:0];

    // Sign extension comes from the signed casts: each field is assembled with bit 31 on top.
    always_comb begin
        dec_type = T_NONE;
        dec_imm  = '0;
        case (INSTR_IN[6:2])
            5'b01101, 5'b00101: begin
                dec_type = T_U;
                dec_imm  = XLEN'($signed({INSTR_IN[31:12], 12'b0}));
            end
            5'b11011: begin
                dec_type = T_J;
                dec_imm  = XLEN'($signed({INSTR_IN[31], INSTR_IN[19:12], INSTR_IN[20],
                                          INSTR_IN[30:21], 1'b0}));
            end
            5'b11001, 5'b00000, 5'b00001, 5'b00100, 5'b00110: begin
                dec_type = T_I;
                dec_imm  = XLEN'($signed(INSTR_IN[31:20]));
            end
            5'b01000, 5'b01001: begin
                dec_type = T_S;
                dec_imm  = XLEN'($signed({INSTR_IN[31:25], INSTR_IN[11:7]}));
            end
            5'b11000: begin
                dec_type = T_B;
                dec_imm  = XLEN'($signed({INSTR_IN[31], INSTR_IN[7], INSTR_IN[30:25],
                                          INSTR_IN[11:8], 1'b0}));
            end
`ifdef IMM_GEN_CSR_ZIMM_EN
            5'b11100: begin
                if (INSTR_IN[14]) begin
                    dec_type = T_Z;
                    dec_imm  = XLEN'(INSTR_IN[19:15]);
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_imm_q   <= '0;
            out_type_q  <= T_NONE;
            skid_imm_q  <= '0;
            skid_type_q <= T_NONE;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_imm_q   <= out_imm_d;
            out_type_q  <= out_type_d;
            skid_imm_q  <= skid_imm_d;
            skid_type_q <= skid_type_d;
        end
    end

    // in_ready is registered, so it is derived from the next state rather than the current one.
    always_comb begin
        state_d     = state_q;
        out_imm_d   = out_imm_q;
        out_type_d  = out_type_q;
        skid_imm_d  = skid_imm_q;
        skid_type_d = skid_type_q;
        accept      = in_valid && in_ready_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d    = ONE;
                        out_imm_d  = dec_imm;
                        out_type_d = dec_type;
                    end
                end
                ONE: begin
                    if (accept && !out_ready) begin
                        state_d     = TWO;
                        skid_imm_d  = dec_imm;
                        skid_type_d = dec_type;
                    end else if (accept) begin
                        out_imm_d  = dec_imm;
                        out_type_d = dec_type;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        state_d    = ONE;
                        out_imm_d  = skid_imm_q;
                        out_type_d = skid_type_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        IMM_OUT   = out_imm_q;
        IMM_TYPE  = out_type_q;
    end

    assign in_ready = in_ready_q;

endmodule
